leela_mc_arb: RTL and testbench
===============================

Name: leela_mc_arb

Overview:
Arbiter and sequencer for the shared video SRAM controller port in the leela camera/VGA subsystem. It arbitrates between three Wishbone requesters: port 0 is the CPU slave window, port 1 is the camera write master, port 2 is the VGA read master. It issues a registered one-hot grant, routes the memory sequencer's ack back to the owner, holds the grant across bursts, guarantees bounded wait for the low-priority ports and enforces a no-ack watchdog.

Parameters:
MAX_WAIT, 64, cycles a pending port 0/1 request may wait before it overrides VGA priority.
TIMEOUT, 255, cycles without mem_ack_i while granted before the bus error fires.
CW, 8, width of the wait and timeout counters; must satisfy 2^CW > max(MAX_WAIT, TIMEOUT).

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
cyc_i  in  3  per-port Wishbone cyc, bit n = port n
stb_i  in  3  per-port Wishbone stb
cti_i  in  9  per-port cti, port n at bits [3n+2:3n]
mem_ack_i  in  1  beat ack from the memory sequencer
gnt_o  out  3  one-hot grant, registered
sel_o  out  2  encoded owner (0..2), valid when gnt_o != 0
ack_o  out  3  mem_ack_i steered to the owner
err_o  out  3  one-cycle timeout error to the owner
busy_o  out  1  state != IDLE
starve_o  out  2  sticky flags: port 0/1 starvation override used; cleared by rst only

Behaviour:
- Reset (sync, rst=1 at posedge) has these required values:
  - state=IDLE; gnt_o=0, sel_o=0, err_o=0, busy_o=0, starve_o=0.
  - All counters 0; round-robin pointer rr=0, so port 0 is favoured next.
  - ack_o=0, because it is gated by gnt_o.
- Reset mid-transaction drops the grant the next cycle with no error pulse.
- Request for port n: req[n] = cyc_i[n] & stb_i[n].
- States are IDLE, GRANT, ERR and DRAIN.
- IDLE:
  - If any req is set, the winner is registered into gnt_o/sel_o and the FSM moves to GRANT.
  - Latency is 1 cycle: request at edge k gives gnt_o at edge k+1.
- Priority order:
  - A starved port (0 or 1) wins first. If both are starved, rr decides.
  - Otherwise port 2 (VGA) wins.
  - Otherwise port 0 vs port 1 is decided by rr. rr toggles to the other port whenever port 0 or 1 is granted.
- Wait counters (ports 0 and 1):
  - The counter increments each cycle that req[n] is set and gnt_o[n]=0.
  - It resets to 0 on grant, or when req[n] is low.
  - It saturates and never wraps.
  - Port n is starved when its counter >= MAX_WAIT. The matching starve_o bit is set when that port wins by the override.
- GRANT:
  - ack_o = gnt_o & {3{mem_ack_i}}, combinational.
  - The timeout counter clears on each mem_ack_i and otherwise increments.
  - Exit to IDLE, with gnt_o cleared on the next edge, when either:
    - cyc_i[sel] falls; or
    - mem_ack_i arrives with cti of the owner = 3'b111 (end of burst).
  - Classic cycles (cti 000) and incrementing bursts (010) both hold the grant until cyc falls.
  - After every release gnt_o is 0 for at least one cycle. This is the SRAM bus turnaround.
  - Exit to ERR when the timeout counter reaches TIMEOUT.
- ERR: err_o[sel]=1 for exactly one cycle, gnt_o held; then go to DRAIN.
- DRAIN: gnt_o held and ack_o suppressed until cyc_i[sel]=0; then go to IDLE.
- Simultaneous events:
  - mem_ack_i on the same cycle as the timeout: the ack wins and the counter clears.
  - cyc drop on the same cycle as a final ack: a single release.
  - Requests from other ports during GRANT are only counted; there is never preemption.
- mem_ack_i in IDLE is ignored; ack_o stays 0.

Decomposition:
- Shared package leela_pkg holds:
  - the state enum arb_state_t (IDLE, GRANT, ERR, DRAIN);
  - port index constants PORT_CPU=0, PORT_CAM=1, PORT_VGA=2;
  - CTI constants CTI_CLASSIC=3'b000, CTI_INCR=3'b010, CTI_EOB=3'b111.
- One sub-module, leela_arb_pick: combinational priority/round-robin picker.
  - Inputs: req, starved, rr.
  - Outputs: one-hot winner and encoded index.
- The counters and FSM stay in leela_mc_arb.

Test Plan:
- Reset, then only VGA requests at cycle 10 -> gnt_o=3'b100 at cycle 11. Four acks with cti 010,010,010,111 -> gnt_o=0 at the cycle after the 4th ack.
- Ports 0 and 1 request continuously, port 2 idle, classic single-beat cycles -> grants alternate 001,010,001,010 with one zero-grant cycle between each.
- Port 0 requests while VGA re-requests back-to-back (MAX_WAIT=64) -> port 0 granted no later than 66 cycles after its request; starve_o[0]=1.
- Camera granted, memory never acks (TIMEOUT=255) -> err_o=3'b010 for one cycle at 255 cycles after the grant. Grant is held until cyc_i[1] drops, then gnt_o=0 the next cycle.
- rst asserted for one cycle in mid-burst of port 2 -> next cycle gnt_o=0, ack_o=0, err_o=0, state IDLE. A pending port 0 request is granted the cycle after that.
- mem_ack_i pulsed while IDLE with no requests -> ack_o stays 3'b000 and busy_o stays 0.

Source files
------------

// File: rtl/leela_pkg.sv
// Shared types and constants for the leela video SRAM arbiter.
package leela_pkg;

   typedef enum logic [1:0] {
      IDLE,
      GRANT,
      ERR,
      DRAIN
   } arb_state_t;

   localparam int PORT_CPU = 0;
   localparam int PORT_CAM = 1;
   localparam int PORT_VGA = 2;

   localparam logic [2:0] CTI_CLASSIC = 3'b000;
   localparam logic [2:0] CTI_INCR    = 3'b010;
   localparam logic [2:0] CTI_EOB     = 3'b111;

endpackage

// File: rtl/leela_arb_pick.sv
// Combinational winner selection: starved CPU/camera first, then VGA,
// then CPU vs camera by the round-robin pointer (rr=0 favours the CPU).
module leela_arb_pick
   import leela_pkg::*;
(
   input  logic [2:0] req_i,
   input  logic [1:0] starved_i,
   input  logic       rr_i,
   output logic [2:0] win_o,
   output logic [1:0] idx_o
);

   // Index is chosen first; the one-hot form is only driven when someone asks.
   always_comb begin
      idx_o = 2'd0;
      win_o = 3'b000;
      if (starved_i == 2'b11) begin
         idx_o = {1'b0, rr_i};
      end else if (starved_i[0]) begin
         idx_o = 2'(PORT_CPU);
      end else if (starved_i[1]) begin
         idx_o = 2'(PORT_CAM);
      end else if (req_i[2]) begin
         idx_o = 2'(PORT_VGA);
      end else if (req_i[1:0] == 2'b11) begin
         idx_o = {1'b0, rr_i};
      end else if (req_i[1]) begin
         idx_o = 2'(PORT_CAM);
      end else begin
         idx_o = 2'(PORT_CPU);
      end
      if (|req_i) begin
         win_o = 3'b001 << idx_o;
      end
   end

endmodule

// File: rtl/leela_mc_arb.sv
// Shared video SRAM port arbiter: registered one-hot grant held across bursts,
// starvation override for the CPU/camera ports and a no-ack watchdog.
module leela_mc_arb
   import leela_pkg::*;
#(
   parameter int MAX_WAIT = 64,
   parameter int TIMEOUT  = 255,
   parameter int CW       = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [2:0] cyc_i,
   input  logic [2:0] stb_i,
   input  logic [8:0] cti_i,
   input  logic       mem_ack_i,
   output logic [2:0] gnt_o,
   output logic [1:0] sel_o,
   output logic [2:0] ack_o,
   output logic [2:0] err_o,
   output logic       busy_o,
   output logic [1:0] starve_o
);

   localparam logic [CW-1:0] MaxWaitC = CW'(MAX_WAIT);
   localparam logic [CW-1:0] TimeoutC = CW'(TIMEOUT);
   localparam logic [CW-1:0] OneC     = {{(CW-1){1'b0}}, 1'b1};
   localparam logic [CW-1:0] SatC     = '1;

   arb_state_t    state_q, state_d;
   logic [2:0]    gnt_q, gnt_d;
   logic [1:0]    sel_q, sel_d;
   logic          rr_q, rr_d;
   logic [1:0]    starve_q, starve_d;
   logic [CW-1:0] wait0_q, wait0_d, wait1_q, wait1_d, tout_q, tout_d;

   logic [2:0] req, win;
   logic [1:0] starved, winIdx;
   logic       ownerCyc;
   logic [2:0] ownerCti;

   function automatic logic [CW-1:0] satInc(input logic [CW-1:0] v);
      return (v == SatC) ? v : v + OneC;
   endfunction

   assign req     = cyc_i & stb_i;
   assign starved = {wait1_q >= MaxWaitC, wait0_q >= MaxWaitC} & req[1:0];
   assign wait0_d = (req[0] && !gnt_q[0]) ? satInc(wait0_q) : '0;
   assign wait1_d = (req[1] && !gnt_q[1]) ? satInc(wait1_q) : '0;

   leela_arb_pick uPick (
      .req_i    (req),
      .starved_i(starved),
      .rr_i     (rr_q),
      .win_o    (win),
      .idx_o    (winIdx)
   );

   always_comb begin
      ownerCyc = 1'b0;
      ownerCti = CTI_CLASSIC;
      case (sel_q)
         2'(PORT_CPU): begin ownerCyc = cyc_i[0]; ownerCti = cti_i[2:0]; end
         2'(PORT_CAM): begin ownerCyc = cyc_i[1]; ownerCti = cti_i[5:3]; end
         2'(PORT_VGA): begin ownerCyc = cyc_i[2]; ownerCti = cti_i[8:6]; end
         default:      begin ownerCyc = 1'b0;     ownerCti = CTI_CLASSIC; end
      endcase
   end

   // A release always passes through IDLE with the grant low, which gives the
   // SRAM bus its turnaround cycle; a release wins over a same-cycle timeout.
   always_comb begin
      state_d  = state_q;
      gnt_d    = gnt_q;
      sel_d    = sel_q;
      rr_d     = rr_q;
      starve_d = starve_q;
      tout_d   = '0;
      unique case (state_q)
         IDLE: begin
            if (|req) begin
               gnt_d   = win;
               sel_d   = winIdx;
               state_d = GRANT;
               if (winIdx != 2'(PORT_VGA)) begin
                  rr_d = ~winIdx[0];
                  if (starved[winIdx[0]]) starve_d[winIdx[0]] = 1'b1;
               end
            end
         end
         GRANT: begin
            tout_d = mem_ack_i ? '0 : satInc(tout_q);
            if (!ownerCyc || (mem_ack_i && ownerCti == CTI_EOB)) begin
               state_d = IDLE;
               gnt_d   = '0;
               sel_d   = '0;
            end else if (tout_d == TimeoutC) begin
               state_d = ERR;
            end
         end
         ERR: begin
            state_d = DRAIN;
         end
         DRAIN: begin
            if (!ownerCyc) begin
               state_d = IDLE;
               gnt_d   = '0;
               sel_d   = '0;
            end
         end
         default: begin
            state_d = IDLE;
            gnt_d   = '0;
            sel_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         gnt_q    <= '0;
         sel_q    <= '0;
         rr_q     <= 1'b0;
         starve_q <= '0;
         wait0_q  <= '0;
         wait1_q  <= '0;
         tout_q   <= '0;
      end else begin
         state_q  <= state_d;
         gnt_q    <= gnt_d;
         sel_q    <= sel_d;
         rr_q     <= rr_d;
         starve_q <= starve_d;
         wait0_q  <= wait0_d;
         wait1_q  <= wait1_d;
         tout_q   <= tout_d;
      end
   end

   assign gnt_o    = gnt_q;
   assign sel_o    = sel_q;
   assign ack_o    = (state_q == GRANT) ? (gnt_q & {3{mem_ack_i}}) : 3'b000;
   assign err_o    = (state_q == ERR) ? gnt_q : 3'b000;
   assign busy_o   = (state_q != IDLE);
   assign starve_o = starve_q;

endmodule

// File: tb/tb_leela_mc_arb.sv
// Directed bench for leela_mc_arb: an owner/age/silence model checked every
// cycle, plus hand-computed literal checkpoints per scenario.
module tb_leela_mc_arb;
   import leela_pkg::*;

   localparam int MaxWait = 64;
   localparam int Timeout = 255;

   logic       clk = 1'b0;
   logic       rst;
   logic [2:0] cycI, stbI;
   logic [8:0] ctiI;
   logic       memAck;
   logic [2:0] gnt, ack, err;
   logic [1:0] sel, starve;
   logic       busy;

   int checks = 0;
   int fails  = 0;
   bit checkEn = 1'b0;
   int waited;
   logic [2:0] beatCti [4] = '{CTI_INCR, CTI_INCR, CTI_INCR, CTI_EOB};

   // Model: who owns the bus, per-port waiting age, cycles since the last ack.
   int       mOwner = -1;
   bit       mErring = 1'b0;
   bit       mDraining = 1'b0;
   int       mAge [2] = '{0, 0};
   int       mSilent = 0;
   int       mPrefer = 0;
   bit [1:0] mStarve = 2'b00;

   leela_mc_arb #(.MAX_WAIT(MaxWait), .TIMEOUT(Timeout), .CW(8)) dut (
      .clk      (clk),
      .rst      (rst),
      .cyc_i    (cycI),
      .stb_i    (stbI),
      .cti_i    (ctiI),
      .mem_ack_i(memAck),
      .gnt_o    (gnt),
      .sel_o    (sel),
      .ack_o    (ack),
      .err_o    (err),
      .busy_o   (busy),
      .starve_o (starve)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         fails++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic applyStimulus(input logic [2:0] c, input logic [8:0] t, input logic a);
      cycI   = c;
      stbI   = c;
      ctiI   = t;
      memAck = a;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [8:0] ctiAt(input int p, input logic [2:0] v);
      return 9'(v) << (3 * p);
   endfunction

   // Advance the model by one clock using the inputs held across the edge.
   task automatic modelStep();
      bit [2:0] req;
      int       nextAge [2];
      bit       st [2];
      int       w;
      if (rst) begin
         mOwner = -1; mErring = 0; mDraining = 0; mAge = '{0, 0};
         mSilent = 0; mPrefer = 0; mStarve = 2'b00;
         return;
      end
      req = cycI & stbI;
      for (int n = 0; n < 2; n++)
         nextAge[n] = (req[n] && mOwner != n) ? ((mAge[n] < 255) ? mAge[n] + 1 : 255) : 0;
      if (mOwner < 0) begin
         if (req != 3'b000) begin
            for (int n = 0; n < 2; n++) st[n] = req[n] && (mAge[n] >= MaxWait);
            if (st[0] && st[1])           w = mPrefer;
            else if (st[0])               w = 0;
            else if (st[1])               w = 1;
            else if (req[2])              w = 2;
            else if (req[0] && req[1])    w = mPrefer;
            else                          w = req[0] ? 0 : 1;
            if (w < 2) begin
               if (st[w]) mStarve[w] = 1'b1;
               mPrefer = 1 - w;
            end
            mOwner  = w;
            mSilent = 0;
         end
      end else if (mErring) begin
         mErring   = 0;
         mDraining = 1;
      end else if (mDraining) begin
         if (!cycI[mOwner]) begin
            mOwner    = -1;
            mDraining = 0;
         end
      end else begin
         if (!cycI[mOwner] || (memAck && ctiI[3*mOwner +: 3] == CTI_EOB)) begin
            mOwner = -1;
         end else begin
            mSilent = memAck ? 0 : mSilent + 1;
            if (mSilent >= Timeout) mErring = 1;
         end
      end
      mAge = nextAge;
   endtask

   always @(posedge clk) modelStep();

   // Every output against the model, sampled mid-cycle.
   always @(negedge clk) begin
      logic [2:0] eg;
      if (checkEn) begin
         eg = (mOwner >= 0) ? 3'(1 << mOwner) : 3'b000;
         checkOutput("gnt", 32'(gnt), 32'(eg));
         if (mOwner >= 0) checkOutput("sel", 32'(sel), 32'(mOwner));
         checkOutput("ack", 32'(ack), 32'((mOwner >= 0 && !mErring && !mDraining && memAck) ? eg : 3'b000));
         checkOutput("err", 32'(err), 32'(mErring ? eg : 3'b000));
         checkOutput("busy", 32'(busy), 32'(mOwner >= 0));
         checkOutput("starve", 32'(starve), 32'(mStarve));
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] time limit");
   end

   initial begin
      rst = 1'b1;
      applyStimulus(3'b000, 9'd0, 1'b0);
      tick();
      tick();
      checkOutput("rstGnt", 32'(gnt), 32'(3'b000));
      checkOutput("rstBusy", 32'(busy), 32'(1'b0));
      checkOutput("rstErr", 32'(err), 32'(3'b000));
      checkOutput("rstAck", 32'(ack), 32'(3'b000));
      checkOutput("rstStarve", 32'(starve), 32'(2'b00));
      checkEn = 1'b1;
      rst = 1'b0;
      repeat (8) tick();

      // VGA four-beat burst ending in an end-of-burst ack.
      applyStimulus(3'b100, ctiAt(PORT_VGA, CTI_INCR), 1'b0);
      tick();
      checkOutput("vgaGnt", 32'(gnt), 32'(3'b100));
      checkOutput("vgaSel", 32'(sel), 32'(2'd2));
      for (int b = 0; b < 4; b++) begin
         checkOutput("vgaHold", 32'(gnt), 32'(3'b100));
         applyStimulus(3'b100, ctiAt(PORT_VGA, beatCti[b]), 1'b1);
         #1;
         checkOutput("vgaAck", 32'(ack), 32'(3'b100));
         tick();
      end
      checkOutput("vgaRelease", 32'(gnt), 32'(3'b000));
      applyStimulus(3'b000, 9'd0, 1'b0);
      tick();

      // CPU and camera alternate on classic single-beat cycles.
      applyStimulus(3'b011, 9'd0, 1'b0);
      tick();
      for (int k = 0; k < 4; k++) begin
         logic [2:0] exp;
         exp = 3'(1 << (k % 2));
         checkOutput("altGnt", 32'(gnt), 32'(exp));
         applyStimulus(3'b011 & ~exp, 9'd0, 1'b1);
         tick();
         checkOutput("altGap", 32'(gnt), 32'(3'b000));
         applyStimulus(3'b011, 9'd0, 1'b0);
         tick();
      end
      applyStimulus(3'b000, 9'd0, 1'b0);
      tick();
      tick();

      // CPU starves behind back-to-back VGA single beats.
      applyStimulus(3'b101, ctiAt(PORT_VGA, CTI_EOB) | ctiAt(PORT_CPU, CTI_CLASSIC), 1'b1);
      waited = 0;
      while (!gnt[0] && waited < 200) begin
         tick();
         waited++;
      end
      checkOutput("starveWithin66", 32'(waited <= 66), 32'(1));
      checkOutput("starveFlag", 32'(starve), 32'(2'b01));
      applyStimulus(3'b000, 9'd0, 1'b0);
      tick();
      tick();

      // Camera granted, memory never acks.
      applyStimulus(3'b010, ctiAt(PORT_CAM, CTI_CLASSIC), 1'b0);
      tick();
      checkOutput("camGnt", 32'(gnt), 32'(3'b010));
      repeat (254) tick();
      checkOutput("errEarly", 32'(err), 32'(3'b000));
      tick();
      checkOutput("errPulse", 32'(err), 32'(3'b010));
      tick();
      checkOutput("errOnce", 32'(err), 32'(3'b000));
      checkOutput("drainHold", 32'(gnt), 32'(3'b010));
      repeat (3) tick();
      checkOutput("drainHold2", 32'(gnt), 32'(3'b010));
      applyStimulus(3'b000, 9'd0, 1'b0);
      tick();
      checkOutput("drainRelease", 32'(gnt), 32'(3'b000));
      tick();

      // Reset in the middle of a VGA burst with a CPU request waiting.
      applyStimulus(3'b100, ctiAt(PORT_VGA, CTI_INCR), 1'b0);
      tick();
      checkOutput("midGnt", 32'(gnt), 32'(3'b100));
      applyStimulus(3'b100, ctiAt(PORT_VGA, CTI_INCR), 1'b1);
      tick();
      rst = 1'b1;
      applyStimulus(3'b001, ctiAt(PORT_VGA, CTI_INCR), 1'b1);
      tick();
      checkOutput("midRstGnt", 32'(gnt), 32'(3'b000));
      checkOutput("midRstAck", 32'(ack), 32'(3'b000));
      checkOutput("midRstErr", 32'(err), 32'(3'b000));
      checkOutput("midRstBusy", 32'(busy), 32'(1'b0));
      checkOutput("midRstStarve", 32'(starve), 32'(2'b00));
      rst = 1'b0;
      applyStimulus(3'b001, 9'd0, 1'b0);
      tick();
      checkOutput("postRstGnt", 32'(gnt), 32'(3'b001));
      applyStimulus(3'b000, 9'd0, 1'b0);
      tick();
      tick();

      // Stray memory ack while idle.
      applyStimulus(3'b000, 9'd0, 1'b1);
      tick();
      checkOutput("idleAck", 32'(ack), 32'(3'b000));
      checkOutput("idleBusy", 32'(busy), 32'(1'b0));
      tick();
      checkOutput("idleAck2", 32'(ack), 32'(3'b000));
      applyStimulus(3'b000, 9'd0, 1'b0);
      tick();

      checkEn = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
